// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-address unit.
// Decoded operation enum and default parameter values.
package pc_pkg;

  localparam int DEF_ADDR_W      = 11;
  localparam int DEF_STACK_DEPTH = 8;
  localparam int DEF_RESET_ADDR  = 0;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_BRANCH,
    OP_CALL,
    OP_RET
  } pc_op_e;

endpackage

// File: rtl/pc_stack_unit_ras_stack.sv
// Return-address LIFO.
// Only the count is reset; entry storage is don't-care after reset.
module ras_stack #(
  parameter int ADDR_W      = 11,
  parameter int STACK_DEPTH = 8,
  localparam int CW = $clog2(STACK_DEPTH + 1),
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] mem [0:(1<<IW)-1];
  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     wr_idx;

  assign full    = (count == CW'(STACK_DEPTH));
  assign empty   = (count == '0);
  assign top_idx = IW'(count - CW'(1));
  assign wr_idx  = IW'(count);
  assign top     = mem[top_idx];

  // Entry write on an accepted push.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

  // Occupancy tracking; push and pop are exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with return-address stack.
// Priority decode of ret/call/branch/inc, pc register, sticky flags.
import pc_pkg::*;

module pc_stack_unit #(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int RESET_ADDR  = DEF_RESET_ADDR,
  localparam int CW = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              inc,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              call_en,
  input  logic [ADDR_W-1:0] call_addr,
  input  logic              ret_en,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] pc,
  output logic [CW-1:0]     stack_count,
  output logic              stack_overflow,
  output logic              stack_underflow
);

  pc_op_e            op;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] top;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              set_ovf;
  logic              set_unf;

  assign pc_inc  = pc + ADDR_W'(1);
  assign push    = (op == OP_CALL) && !full;
  assign pop     = (op == OP_RET) && !empty;
  assign set_ovf = (op == OP_CALL) && full;
  assign set_unf = (op == OP_RET) && empty;

  // Pick one operation per cycle; stall forces hold.
  always_comb begin
    op = OP_HOLD;
    if (!stall) begin
      priority case (1'b1)
        ret_en:    op = OP_RET;
        call_en:   op = OP_CALL;
        branch_en: op = OP_BRANCH;
        inc:       op = OP_INC;
        default:   op = OP_HOLD;
      endcase
    end
  end

  ras_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (top),
    .count (stack_count),
    .full  (full),
    .empty (empty)
  );

  // Fetch address update; refused call/ret fall through to pc+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= ADDR_W'(RESET_ADDR);
    end else begin
      unique case (op)
        OP_RET:    pc <= empty ? pc_inc : top;
        OP_CALL:   pc <= full ? pc_inc : call_addr;
        OP_BRANCH: pc <= branch_addr;
        OP_INC:    pc <= pc_inc;
        default:   pc <= pc;
      endcase
    end
  end

  // Sticky misuse flags; a new error beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (!stall) begin
      stack_overflow  <= (stack_overflow & ~err_clr) | set_ovf;
      stack_underflow <= (stack_underflow & ~err_clr) | set_unf;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit.
// Queue-based reference model plus directed literal checks.
module tb_pc_stack_unit;

  localparam int AW = 11;
  localparam int D  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          inc = 1'b0;
  logic          branch_en = 1'b0;
  logic [AW-1:0] branch_addr = '0;
  logic          call_en = 1'b0;
  logic [AW-1:0] call_addr = '0;
  logic          ret_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [AW-1:0] pc;
  logic [CW-1:0] stack_count;
  logic          stack_overflow;
  logic          stack_underflow;

  pc_stack_unit #(
    .ADDR_W      (AW),
    .STACK_DEPTH (D),
    .RESET_ADDR  (0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .inc             (inc),
    .branch_en       (branch_en),
    .branch_addr     (branch_addr),
    .call_en         (call_en),
    .call_addr       (call_addr),
    .ret_en          (ret_en),
    .err_clr         (err_clr),
    .pc              (pc),
    .stack_count     (stack_count),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int            m_pc;
  int            m_stk[$];
  bit            m_ovf;
  bit            m_unf;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_edge();
    int nxt;
    bit so;
    bit su;
    if (stall) return;
    nxt = (m_pc + 1) % (1 << AW);
    so = 0;
    su = 0;
    if (ret_en) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_pc = nxt; su = 1; end
    end else if (call_en) begin
      if (m_stk.size() < D) begin
        m_stk.push_back(nxt);
        m_pc = int'(call_addr);
      end else begin
        m_pc = nxt;
        so = 1;
      end
    end else if (branch_en) begin
      m_pc = int'(branch_addr);
    end else if (inc) begin
      m_pc = nxt;
    end
    if (err_clr) begin m_ovf = 0; m_unf = 0; end
    m_ovf = m_ovf | so;
    m_unf = m_unf | su;
  endtask

  task automatic compare();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("stack_count", 32'(stack_count), 32'(m_stk.size()));
    chk("stack_overflow", 32'(stack_overflow), 32'(m_ovf));
    chk("stack_underflow", 32'(stack_underflow), 32'(m_unf));
  endtask

  task automatic idle();
    stall = 0; inc = 0; branch_en = 0; call_en = 0;
    ret_en = 0; err_clr = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    idle();
  endtask

  task automatic do_branch(int a);
    branch_en = 1; branch_addr = AW'(a); cyc();
  endtask

  task automatic do_call(int a);
    call_en = 1; call_addr = AW'(a); cyc();
  endtask

  task automatic do_ret();
    ret_en = 1; cyc();
  endtask

  initial begin
    model_reset();
    #2;
    compare();
    chk("reset_pc", 32'(pc), 32'h0);
    #10 rst = 0;

    // Five increments from reset.
    for (int i = 1; i <= 5; i++) begin
      inc = 1; cyc();
      chk("inc_seq", 32'(pc), 32'(i));
    end
    chk("inc_count", 32'(stack_count), 0);

    // Call then immediate return.
    do_branch('h010);
    do_call('h200);
    chk("call_pc", 32'(pc), 32'h200);
    chk("call_cnt", 32'(stack_count), 1);
    do_ret();
    chk("ret_pc", 32'(pc), 32'h011);
    chk("ret_cnt", 32'(stack_count), 0);

    // Nested calls to overflow, unwind to underflow.
    do_branch('h100);
    for (int i = 0; i < 8; i++) do_call('h300 + i);
    chk("full_cnt", 32'(stack_count), 8);
    do_call('h3F0);
    chk("ovf_pc", 32'(pc), 32'h308);
    chk("ovf_flag", 32'(stack_overflow), 1);
    for (int k = 0; k < 8; k++) begin
      do_ret();
      chk("unwind", 32'(pc), (k < 7) ? 32'(32'h307 - k) : 32'h101);
    end
    do_ret();
    chk("unf_pc", 32'(pc), 32'h102);
    chk("unf_flag", 32'(stack_underflow), 1);
    err_clr = 1; cyc();
    chk("clr_ovf", 32'(stack_overflow), 0);
    chk("clr_unf", 32'(stack_underflow), 0);

    // All requests at once, first stalled then live.
    do_branch('h050);
    do_call('h400);
    do_call('h410);
    stall = 1; ret_en = 1; call_en = 1; branch_en = 1; inc = 1;
    branch_addr = 'h555; call_addr = 'h666; cyc();
    chk("stall_pc", 32'(pc), 32'h410);
    chk("stall_cnt", 32'(stack_count), 2);
    ret_en = 1; call_en = 1; branch_en = 1; inc = 1;
    branch_addr = 'h555; call_addr = 'h666; cyc();
    chk("prio_pc", 32'(pc), 32'h401);
    chk("prio_cnt", 32'(stack_count), 1);
    do_ret();
    do_ret();
    err_clr = 1; cyc();

    // Wraparound of pc and pushed return address.
    do_branch('h7FF);
    inc = 1; cyc();
    chk("wrap_inc", 32'(pc), 32'h000);
    do_branch('h7FF);
    do_call('h123);
    do_ret();
    chk("wrap_ret", 32'(pc), 32'h000);

    // Async reset between edges.
    do_ret();
    do_call('h010);
    do_call('h020);
    do_call('h123);
    chk("pre_rst_cnt", 32'(stack_count), 3);
    chk("pre_rst_unf", 32'(stack_underflow), 1);
    #3 rst = 1;
    #1;
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_cnt", 32'(stack_count), 0);
    chk("arst_unf", 32'(stack_underflow), 0);
    chk("arst_ovf", 32'(stack_overflow), 0);
    model_reset();
    @(posedge clk);
    #3 rst = 0;
    #1;
    compare();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      stall   = ($urandom_range(0, 9) == 0);
      ret_en  = ($urandom_range(0, 3) == 0);
      call_en = ($urandom_range(0, 2) == 0);
      branch_en = ($urandom_range(0, 4) == 0);
      inc     = ($urandom_range(0, 1) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      branch_addr = ($urandom_range(0, 3) == 0)
                    ? AW'(11'h7FF - $urandom_range(0, 2))
                    : AW'($urandom);
      call_addr = ($urandom_range(0, 3) == 0)
                  ? AW'(11'h7FF)
                  : AW'($urandom);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
